nand_page_read_ctrl: RTL and testbench

Sequencer for one NAND flash page read over the 8-bit shared I/O bus. Drives the raw control pins (WE, CE, CLE, ALE, RE) with the same CPINS bit mapping as the existing read-data path. It issues the read-setup command, five address cycles and the read-confirm command, then waits on R/B#. It then clocks out a requested number of bytes, presenting each as a one-cycle valid strobe to the host side.

---
 rtl/nand_page_read_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_nand_page_read_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nand_page_read_ctrl.sv
// nand_page_read_ctrl
// Sequences one NAND flash page read over the shared 8-bit I/O bus:
// read-setup command, five address cycles, read-confirm command, a wait on
// R/B#, then a RE#-clocked burst of the requested number of bytes.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle request, honoured only in IDLE
//   col_addr/row_addr : page address, latched on an accepted start
//   data_amount       : byte count, latched on an accepted start (0 allowed)
//   rb_n              : NAND ready/busy (low = busy)
//   in                : NAND I/O bus input
//   io_out, io_oe     : NAND I/O bus drive value and drive enable
//   CPINS             : [0]=WE# [1]=CE# [2]=CLE [3]=ALE [4]=RE#
//   data_out          : last captured read byte
//   data_valid        : one-cycle strobe, data_out holds a new byte
//   busy              : high from accepted start through the done cycle
//   done              : one-cycle completion pulse
//   timeout_err       : set with done when R/B# never rose; cleared on next start
module nand_page_read_ctrl #(
  parameter int unsigned TWB_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  CMD_READ1      = 8'h00,
  parameter logic [7:0]  CMD_READ2      = 8'h30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] col_addr,
  input  logic [23:0] row_addr,
  input  logic [15:0] data_amount,
  input  logic        rb_n,
  input  logic [7:0]  in,
  output logic [7:0]  io_out,
  output logic        io_oe,
  output logic [4:0]  CPINS,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD1_L, ST_CMD1_H, ST_ADDR_L, ST_ADDR_H, ST_CMD2_L, ST_CMD2_H,
    ST_WAIT_BUSY, ST_WAIT_READY, ST_RD_L, ST_RD_H, ST_DONE
  } state_t;

  // Wait counters compare against the last cycle index, so a state lasts
  // exactly N cycles when the counter starts at zero on entry.
  localparam logic [15:0] TWB_LAST = 16'(TWB_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [15:0] col_r;
  logic [23:0] row_r;
  logic [15:0] amount_r;
  logic [2:0]  addr_cnt_r;
  logic [15:0] byte_cnt_r;
  logic [15:0] wait_cnt_r;
  logic        we_r, ce_r, cle_r, ale_r, re_r;
  logic [7:0]  io_out_r;
  logic        io_oe_r;
  logic [7:0]  data_out_r;
  logic        data_valid_r, busy_r, done_r, timeout_err_r;

  // Address byte for each of the five address cycles, column first, LSB first.
  function automatic logic [7:0] addr_byte(input logic [2:0]  idx,
                                           input logic [15:0] col,
                                           input logic [23:0] row);
    logic [7:0] b;
    case (idx)
      3'd0:    b = col[7:0];
      3'd1:    b = col[15:8];
      3'd2:    b = row[7:0];
      3'd3:    b = row[15:8];
      3'd4:    b = row[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Sequencer: state and every output register are updated together, so each
  // output reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      col_r         <= 16'h0000;
      row_r         <= 24'h000000;
      amount_r      <= 16'h0000;
      addr_cnt_r    <= 3'd0;
      byte_cnt_r    <= 16'h0000;
      wait_cnt_r    <= 16'h0000;
      we_r          <= 1'b1;
      ce_r          <= 1'b1;
      cle_r         <= 1'b0;
      ale_r         <= 1'b0;
      re_r          <= 1'b1;
      io_out_r      <= 8'h00;
      io_oe_r       <= 1'b0;
      data_out_r    <= 8'h00;
      data_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            col_r         <= col_addr;
            row_r         <= row_addr;
            amount_r      <= data_amount;
            byte_cnt_r    <= 16'h0000;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b1;
            ce_r          <= 1'b0;
            cle_r         <= 1'b1;
            we_r          <= 1'b0;
            io_oe_r       <= 1'b1;
            io_out_r      <= CMD_READ1;
            state_r       <= ST_CMD1_L;
          end
        end
        ST_CMD1_L: begin
          we_r    <= 1'b1;
          state_r <= ST_CMD1_H;
        end
        ST_CMD1_H: begin
          cle_r      <= 1'b0;
          ale_r      <= 1'b1;
          we_r       <= 1'b0;
          addr_cnt_r <= 3'd0;
          io_out_r   <= addr_byte(3'd0, col_r, row_r);
          state_r    <= ST_ADDR_L;
        end
        ST_ADDR_L: begin
          we_r    <= 1'b1;
          state_r <= ST_ADDR_H;
        end
        ST_ADDR_H: begin
          we_r <= 1'b0;
          if (addr_cnt_r == 3'd4) begin
            ale_r    <= 1'b0;
            cle_r    <= 1'b1;
            io_out_r <= CMD_READ2;
            state_r  <= ST_CMD2_L;
          end else begin
            addr_cnt_r <= addr_cnt_r + 3'd1;
            io_out_r   <= addr_byte(addr_cnt_r + 3'd1, col_r, row_r);
            state_r    <= ST_ADDR_L;
          end
        end
        ST_CMD2_L: begin
          we_r    <= 1'b1;
          state_r <= ST_CMD2_H;
        end
        ST_CMD2_H: begin
          cle_r      <= 1'b0;
          io_oe_r    <= 1'b0;
          wait_cnt_r <= 16'h0000;
          state_r    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A ready line that never drops still costs the full tWB window.
          if (!rb_n || (wait_cnt_r == TWB_LAST)) begin
            wait_cnt_r <= 16'h0000;
            state_r    <= ST_WAIT_READY;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_WAIT_READY: begin
          if (rb_n) begin
            if (amount_r == 16'h0000) begin
              ce_r    <= 1'b1;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              re_r    <= 1'b0;
              state_r <= ST_RD_L;
            end
          end else if (wait_cnt_r == TO_LAST) begin
            timeout_err_r <= 1'b1;
            ce_r          <= 1'b1;
            done_r        <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_RD_L: begin
          // Byte is taken at the RE# rising edge, i.e. at the end of RD_L.
          re_r         <= 1'b1;
          data_out_r   <= in;
          data_valid_r <= 1'b1;
          byte_cnt_r   <= byte_cnt_r + 16'd1;
          state_r      <= ST_RD_H;
        end
        ST_RD_H: begin
          if (byte_cnt_r < amount_r) begin
            re_r    <= 1'b0;
            state_r <= ST_RD_L;
          end else begin
            ce_r    <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r   <= 1'b0;
          io_out_r <= 8'h00;
          state_r  <= ST_IDLE;
        end
        default: begin
          we_r     <= 1'b1;
          ce_r     <= 1'b1;
          cle_r    <= 1'b0;
          ale_r    <= 1'b0;
          re_r     <= 1'b1;
          io_oe_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign CPINS       = {re_r, ale_r, cle_r, ce_r, we_r};
  assign io_out      = io_out_r;
  assign io_oe       = io_oe_r;
  assign data_out    = data_out_r;
  assign data_valid  = data_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_nand_page_read_ctrl.sv
// Directed bench for nand_page_read_ctrl. Cycles are numbered from the start
// acceptance edge: cycle 1 is CMD1_L. rb_n is driven per cycle number and a
// simple NAND model returns A0, A1, ... on successive RE# low cycles.
module tb_nand_page_read_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, rb_n;
  logic [15:0] col_addr, data_amount;
  logic [23:0] row_addr;
  logic [7:0]  nand_in, io_out, data_out;
  logic        io_oe, data_valid, busy, done, timeout_err;
  logic [4:0]  cpins;

  always #5 clk = ~clk;

  nand_page_read_ctrl #(
    .TWB_CYCLES(8), .TIMEOUT_CYCLES(100), .CMD_READ1(8'h00), .CMD_READ2(8'h30)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .col_addr(col_addr), .row_addr(row_addr),
    .data_amount(data_amount), .rb_n(rb_n), .in(nand_in), .io_out(io_out),
    .io_oe(io_oe), .CPINS(cpins), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observation state, rebuilt every cycle by sample().
  int          rel;
  logic [63:0] wr_pack, rd_pack;
  logic [6:0]  cle_pat, ale_pat;
  int          wr_cnt, dv_cnt, done_cnt, re_cnt, hold_err;
  int          first_dv_rel, first_re_rel, done_rel;
  logic        terr_at_done, busy_at_done, terr_c1, busy_c1, prev_we;
  logic [7:0]  prev_io;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rel = 0; wr_pack = 64'h0; rd_pack = 64'h0; cle_pat = 7'h0; ale_pat = 7'h0;
    wr_cnt = 0; dv_cnt = 0; done_cnt = 0; re_cnt = 0; hold_err = 0;
    first_dv_rel = -1; first_re_rel = -1; done_rel = -1;
    terr_at_done = 1'b0; busy_at_done = 1'b0; terr_c1 = 1'b1; busy_c1 = 1'b0;
    prev_we = 1'b1; prev_io = 8'h00;
  endtask

  task automatic sample();
    if (!cpins[0]) begin
      wr_pack = {wr_pack[55:0], io_out};
      cle_pat = {cle_pat[5:0], cpins[2]};
      ale_pat = {ale_pat[5:0], cpins[3]};
      wr_cnt++;
    end
    if (!prev_we && cpins[0] && (io_out !== prev_io)) hold_err++;
    prev_we = cpins[0];
    prev_io = io_out;
    if (!cpins[4]) begin
      if (re_cnt == 0) first_re_rel = rel;
      nand_in = 8'hA0 + 8'(re_cnt);
      re_cnt++;
    end
    if (data_valid) begin
      if (dv_cnt == 0) first_dv_rel = rel;
      rd_pack = {rd_pack[55:0], data_out};
      dv_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
      terr_at_done = timeout_err;
      busy_at_done = busy;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
    sample();
  endtask

  // One operation; rb_n is low for cycles lo_first..lo_last. Returns after
  // done plus three idle cycles, at max_rel, or once stop_dv bytes arrived.
  task automatic run_op(input logic [15:0] col, input logic [23:0] row,
                        input logic [15:0] amt, input int lo_first, input int lo_last,
                        input bit second_start, input int stop_dv, input int max_rel);
    clear_mon();
    col_addr = col; row_addr = row; data_amount = amt; start = 1'b1;
    tick();
    start = 1'b0;
    terr_c1 = timeout_err;
    busy_c1 = busy;
    while (rel < max_rel && done_cnt == 0 && !(stop_dv > 0 && dv_cnt >= stop_dv)) begin
      rb_n = (rel >= lo_first && rel <= lo_last) ? 1'b0 : 1'b1;
      if (second_start && rel == 5) begin
        start = 1'b1; col_addr = 16'hFFFF; row_addr = 24'hFFFFFF; data_amount = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    rb_n  = 1'b1;
    if (done_cnt > 0) begin
      for (int i = 0; i < 3; i++) tick();
      check_eq("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_cmd_addr(input string tag);
    check_eq({tag, "_wr_cnt"}, 64'(wr_cnt), 64'd7);
    check_eq({tag, "_wr_bytes"}, {8'h00, wr_pack[55:0]}, 64'h00_00230178560430);
    check_eq({tag, "_cle"}, 64'(cle_pat), 64'(7'b1000001));
    check_eq({tag, "_ale"}, 64'(ale_pat), 64'(7'b0111110));
    check_eq({tag, "_we_hold"}, 64'(hold_err), 64'd0);
  endtask

  initial begin
    clear_mon();
    rst = 1'b1; start = 1'b1; rb_n = 1'b1; nand_in = 8'h00;
    col_addr = 16'h0; row_addr = 24'h0; data_amount = 16'd1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0; start = 1'b0;
    check_eq("rst_cpins", 64'(cpins), 64'(5'b10011));
    check_eq("rst_io_oe", 64'(io_oe), 64'd0);
    check_eq("rst_io_out", 64'(io_out), 64'd0);
    check_eq("rst_data_out", 64'(data_out), 64'd0);
    check_eq("rst_flags", 64'({data_valid, busy, done, timeout_err}), 64'd0);
    for (int i = 0; i < 2; i++) tick();
    check_eq("rst_start_ignored", 64'({busy, cpins[1]}), 64'(2'b01));

    // Basic read: rb_n low 20 cycles from WAIT_BUSY entry (15..34), up at 35.
    run_op(16'h0123, 24'h045678, 16'd4, 15, 34, 1'b0, 0, 200);
    check_cmd_addr("basic");
    check_eq("basic_busy_c1", 64'(busy_c1), 64'd1);
    check_eq("basic_dv_cnt", 64'(dv_cnt), 64'd4);
    check_eq("basic_data", rd_pack, 64'hA0A1A2A3);
    check_eq("basic_first_dv", 64'(first_dv_rel), 64'd37);
    check_eq("basic_done_cyc", 64'(done_rel), 64'd44);
    check_eq("basic_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("basic_done_flags", 64'({busy_at_done, terr_at_done}), 64'(2'b10));

    // Zero length: done one cycle after rb_n rises, no RE# pulse.
    run_op(16'h0123, 24'h045678, 16'd0, 15, 34, 1'b0, 0, 200);
    check_cmd_addr("zero");
    check_eq("zero_re_cnt", 64'(re_cnt), 64'd0);
    check_eq("zero_done_cyc", 64'(done_rel), 64'd36);
    check_eq("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Timeout: WAIT_READY from cycle 16 lasts 100 cycles, DONE at 116.
    run_op(16'h0010, 24'h000020, 16'd2, 15, 100000, 1'b0, 0, 300);
    check_eq("to_done_cyc", 64'(done_rel), 64'd116);
    check_eq("to_terr", 64'(terr_at_done), 64'd1);
    check_eq("to_dv_cnt", 64'(dv_cnt), 64'd0);
    check_eq("to_terr_held", 64'(timeout_err), 64'd1);

    // No busy edge: WAIT_BUSY 15..22, WAIT_READY 23, RD_L 24.
    run_op(16'h0123, 24'h045678, 16'd2, 0, -1, 1'b0, 0, 200);
    check_eq("nobusy_terr_cleared", 64'(terr_c1), 64'd0);
    check_eq("nobusy_first_re", 64'(first_re_rel), 64'd24);
    check_eq("nobusy_first_dv", 64'(first_dv_rel), 64'd25);
    check_eq("nobusy_done_cyc", 64'(done_rel), 64'd28);
    check_eq("nobusy_data", rd_pack, 64'hA0A1);

    // Second start during ADDR is ignored.
    run_op(16'h0123, 24'h045678, 16'd1, 15, 17, 1'b1, 0, 200);
    check_cmd_addr("restart");
    check_eq("restart_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("restart_done_cyc", 64'(done_rel), 64'd21);
    check_eq("restart_data", rd_pack, 64'hA0);

    // Reset after the 2nd data_valid of an 8-byte read.
    run_op(16'h0123, 24'h045678, 16'd8, 15, 19, 1'b0, 2, 200);
    check_eq("rstmid_dv_cnt", 64'(dv_cnt), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstmid_ce_re", 64'({cpins[4], cpins[1]}), 64'(2'b11));
    check_eq("rstmid_busy_done", 64'({busy, done, io_oe}), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("rstmid_no_done", 64'(done_cnt), 64'd0);
    run_op(16'h0123, 24'h045678, 16'd4, 15, 34, 1'b0, 0, 200);
    check_cmd_addr("after_rst");
    check_eq("after_rst_data", rd_pack, 64'hA0A1A2A3);
    check_eq("after_rst_done_cyc", 64'(done_rel), 64'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
